rv_alu_encode: RTL and testbench

Stream encoder for RV32I R-type ALU instructions. It accepts abstract op requests (add/sub/and/or plus register indices) on a valid/ready channel. It emits 32-bit instruction words, and the matching opcode/funct3/funct7b5 fields, on a buffered valid/ready output channel. The decoded-field outputs connect directly to rv_alu_decode inputs for loopback checking. It feeds the test-program generator and instruction-memory writer.

---
 rtl/rv_alu_encode.sv | 143 ++++++++++++++
 tb/tb_rv_alu_encode.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_alu_encode.sv
// rv_alu_encode: turns abstract R-type ALU requests (add/sub/and/or) into
// RV32I instruction words and queues them in a small circular FIFO. The head
// entry and its decoded opcode/funct3/funct7b5 fields are presented on a
// valid/ready output channel. The outputs are zero whenever the buffer is empty.
module rv_alu_encode #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic             out_funct7b5,
  output logic             busy,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [6:0]     OPCODE_OP = 7'b0110011;

  // Build the R-type word; register indices go in verbatim (x0 is not special).
  function automatic logic [31:0] encode_rtype(input logic [1:0] op,
                                               input logic [4:0] rd,
                                               input logic [4:0] rs1,
                                               input logic [4:0] rs2);
    logic [6:0] funct7;
    logic [2:0] funct3;
    funct7 = 7'b0000000;
    funct3 = 3'b000;
    case (op)
      2'b00:   begin funct7 = 7'b0000000; funct3 = 3'b000; end
      2'b01:   begin funct7 = 7'b0100000; funct3 = 3'b000; end
      2'b10:   begin funct7 = 7'b0000000; funct3 = 3'b111; end
      2'b11:   begin funct7 = 7'b0000000; funct3 = 3'b110; end
      default: begin funct7 = 7'b0000000; funct3 = 3'b000; end
    endcase
    return {funct7, rs2, rs1, funct3, rd, OPCODE_OP};
  endfunction

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] issued_q, issued_d;

  logic             out_valid_s;
  logic             push_s;
  logic             pop_s;
  logic [31:0]      head_s;

  // Handshake qualifiers: ready never looks at out_ready, so a full buffer
  // blocks new requests even in a cycle where the head is being drained.
  always_comb begin
    out_valid_s = (count_q != {(PTR_W+1){1'b0}});
    req_ready   = !rst && !flush && (count_q < FULL_CNT);
    push_s      = req_valid && req_ready;
    pop_s       = out_valid_s && out_ready;
  end

  // Next-state for storage, pointers, occupancy and the issue counter.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    issued_d = issued_q;
    if (flush) begin
      // Flush empties the queue; a pop in the same cycle is not counted.
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {(PTR_W+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = encode_rtype(req_op, req_rd, req_rs1, req_rs2);
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        issued_d = issued_q + CNT_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
        issued_d = issued_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset; reset wins over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W+1){1'b0}};
      issued_q <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      issued_q <= issued_d;
    end
  end

  // Head entry straight from storage, masked to zero when the queue is empty.
  always_comb begin
    if (out_valid_s) begin
      head_s = mem_q[rd_ptr_q];
    end else begin
      head_s = 32'h0000_0000;
    end
    out_valid    = out_valid_s;
    busy         = out_valid_s;
    out_instr    = head_s;
    out_opcode   = head_s[6:0];
    out_funct3   = head_s[14:12];
    out_funct7b5 = head_s[30];
    issued_cnt   = issued_q;
  end

endmodule

// File: tb/tb_rv_alu_encode.sv
// Bench for rv_alu_encode: directed encodings/backpressure/flush/reset cases
// plus a randomized phase, all compared every cycle against a queue model.
module tb_rv_alu_encode;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5, busy;
  logic [3:0]  issued_cnt;

  int          total  = 0;
  int          passed = 0;
  bit          chk_en = 1'b0;
  int unsigned mq[$];
  int          m_cnt  = 0;
  logic [31:0] cmp_exp;

  rv_alu_encode #(.DEPTH(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7b5(out_funct7b5), .busy(busy), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  // Reference encoding from the field definitions, using plain arithmetic.
  function automatic int unsigned ref_enc(int op, int rd, int rs1, int rs2);
    int unsigned f7, f3;
    f7 = (op == 1) ? 32 : 0;
    f3 = (op == 2) ? 7 : ((op == 3) ? 6 : 0);
    return f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 51;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input bit v, input bit [1:0] op, input bit [4:0] rd,
                       input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit ordy, input bit fl);
    req_valid = v; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    out_ready = ordy; flush = fl;
  endtask

  // One clock: advance the model with the inputs present at the edge.
  task automatic step();
    bit pu, po;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_cnt = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      pu = req_valid && (mq.size() < 2);
      po = (mq.size() != 0) && out_ready;
      if (po) begin
        void'(mq.pop_front());
        m_cnt = (m_cnt + 1) % 16;
      end
      if (pu) mq.push_back(ref_enc(req_op, req_rd, req_rs1, req_rs2));
    end
    #1;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_exp = (mq.size() != 0) ? mq[0] : 32'h0;
      check("out_valid", out_valid, mq.size() != 0);
      check("busy", busy, mq.size() != 0);
      check("req_ready", req_ready, !rst && !flush && (mq.size() < 2));
      check("out_instr", out_instr, cmp_exp);
      check("out_opcode", out_opcode, cmp_exp[6:0]);
      check("out_funct3", out_funct3, cmp_exp[14:12]);
      check("out_funct7b5", out_funct7b5, cmp_exp[30]);
      check("issued_cnt", issued_cnt, m_cnt);
    end
  end

  int          d_op[4]   = '{0, 1, 2, 3};
  int          d_rd[4]   = '{1, 1, 5, 31};
  int          d_rs1[4]  = '{2, 2, 6, 31};
  int          d_rs2[4]  = '{3, 3, 7, 31};
  logic [31:0] d_exp[4]  = '{32'h003100B3, 32'h403100B3, 32'h007372B3, 32'h01FFEFB3};
  logic [2:0]  d_f3[4]   = '{3'b000, 3'b000, 3'b111, 3'b110};
  logic        d_f7[4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
  int          saved_cnt;

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    #3;
    check("reset out_instr", out_instr, 32'h0);
    check("reset issued", issued_cnt, 4'd0);

    // Directed encodings, each popped the cycle after it appears.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, d_op[i][1:0], d_rd[i][4:0], d_rs1[i][4:0], d_rs2[i][4:0], 1'b1, 1'b0);
      step();
      drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      #3;
      check("dir valid", out_valid, 1'b1);
      check("dir instr", out_instr, d_exp[i]);
      check("dir opcode", out_opcode, 7'h33);
      check("dir funct3", out_funct3, d_f3[i]);
      check("dir funct7b5", out_funct7b5, d_f7[i]);
      step();
      #3;
      check("dir issued", issued_cnt, 4'(i + 1));
    end

    // Backpressure: two accepted, third refused while full.
    drive(1'b1, 2'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0); step();
    drive(1'b1, 2'd1, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0); step();
    drive(1'b1, 2'd2, 5'd7, 5'd8, 5'd9, 1'b0, 1'b0);
    #3;
    check("full ready", req_ready, 1'b0);
    check("full head", out_instr, 32'h003100B3);
    step();
    #3;
    check("stall stable", out_instr, 32'h003100B3);
    drive(1'b1, 2'd2, 5'd7, 5'd8, 5'd9, 1'b1, 1'b0);
    #1;
    check("full pop-only ready", req_ready, 1'b0);
    step();
    #3;
    check("second head", out_instr, 32'h40628233);
    check("count1 ready", req_ready, 1'b1);
    step();
    #3;
    check("third head", out_instr, 32'h009473B3);
    check("push+pop busy", busy, 1'b1);
    drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    step();

    // Flush with two entries queued and out_ready high.
    drive(1'b1, 2'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0); step();
    drive(1'b1, 2'd3, 5'd10, 5'd11, 5'd12, 1'b0, 1'b0); step();
    saved_cnt = m_cnt;
    drive(1'b1, 2'd0, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1);
    #3;
    check("flush ready", req_ready, 1'b0);
    step();
    drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    #3;
    check("flush valid", out_valid, 1'b0);
    check("flush issued", issued_cnt, saved_cnt);

    // Counter wrap: 17 pops from zero land on 1.
    rst = 1'b1; step(); rst = 1'b0;
    drive(1'b1, 2'd1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) step();
    drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #3;
    check("wrap issued", issued_cnt, 4'd1);

    // Reset with entries queued.
    drive(1'b1, 2'd2, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0); step();
    drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    #3;
    check("rst valid", out_valid, 1'b0);
    check("rst instr", out_instr, 32'h0);
    check("rst issued", issued_cnt, 4'd0);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0);
      step();
    end
    rst = 1'b0;
    drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    step(); step(); step();
    #3;
    check("drained", out_valid, 1'b0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
